// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide sequencer.
//   - op codes carried on i_op
//   - FSM state encoding (plain localparams so legacy code can reuse them)
//   - iteration count of the shift-add / restoring-divide loop
package mips_muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int ITER_COUNT = 32;

  // bit 1 of the op code selects divide, bit 0 selects unsigned
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/unsig_extend.sv
// Zero-extends an unsigned register value to a wider width.
//   i_reg : REG_IN_SIZE-bit input value
//   o_reg : REG_OUT_SIZE-bit zero-extended value
module unsig_extend #(
  parameter int REG_IN_SIZE  = 32,
  parameter int REG_OUT_SIZE = 33
) (
  input  logic [REG_IN_SIZE-1:0]  i_reg,
  output logic [REG_OUT_SIZE-1:0] o_reg
);

  assign o_reg = {{(REG_OUT_SIZE-REG_IN_SIZE){1'b0}}, i_reg};

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style multiply/divide unit owning the HI/LO registers.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start, i_op         : launch MULT/MULTU/DIV/DIVU (ignored while busy)
//   i_op_a, i_op_b        : operands, captured on the accepting edge only
//   i_flush               : abort in-flight operation (HI/LO untouched)
//   i_mthi, i_mtlo        : direct HI/LO writes of i_wr_data, IDLE only
//   o_busy, o_done        : not-IDLE flag, one-cycle completion pulse
//   o_div_by_zero         : qualifies o_done for a zero divisor
//   o_hi, o_lo            : architectural HI/LO
// Flow: IDLE -> PREP (magnitudes) -> RUN (32 steps) -> FIX (signs) -> DONE.
module muldiv_sequencer
  import mips_muldiv_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [DATA_SIZE-1:0] i_op_a,
  input  logic [DATA_SIZE-1:0] i_op_b,
  input  logic                 i_flush,
  input  logic                 i_mthi,
  input  logic                 i_mtlo,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_div_by_zero,
  output logic [DATA_SIZE-1:0] o_hi,
  output logic [DATA_SIZE-1:0] o_lo
);

  localparam int W  = DATA_SIZE;
  localparam int W2 = 2 * DATA_SIZE;

  logic [2:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [W2-1:0] acc_q, acc_d;   // mult: product; div: {remainder, quotient}
  logic [W2-1:0] mcd_q, mcd_d;   // mult: left-shifting multiplicand
  logic [W:0]    dvs_q, dvs_d;   // mult: right-shifting multiplier; div: divisor
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic          dbz_q, dbz_d;

  // operand magnitudes, formed from the captured operands
  logic [W:0] uext_a, uext_b, sext_a, sext_b, mag_a, mag_b;
  logic       is_div, is_sgn, sign_a, sign_b;

  unsig_extend #(.REG_IN_SIZE(W), .REG_OUT_SIZE(W+1)) u_ext_a (.i_reg(opa_q), .o_reg(uext_a));
  unsig_extend #(.REG_IN_SIZE(W), .REG_OUT_SIZE(W+1)) u_ext_b (.i_reg(opb_q), .o_reg(uext_b));

  assign is_div = op_is_div(op_q);
  assign is_sgn = op_is_signed(op_q);
  assign sign_a = is_sgn & opa_q[W-1];
  assign sign_b = is_sgn & opb_q[W-1];
  assign sext_a = {opa_q[W-1], opa_q};
  assign sext_b = {opb_q[W-1], opb_q};
  assign mag_a  = is_sgn ? (sign_a ? -sext_a : sext_a) : uext_a;
  assign mag_b  = is_sgn ? (sign_b ? -sext_b : sext_b) : uext_b;

  // restoring divide step: remainder never exceeds W bits since divisor < 2^W
  logic [W:0] div_shift, div_trial, div_rem;
  logic       div_ge;
  assign div_shift = {acc_q[W2-1:W], acc_q[W-1]};
  assign div_trial = div_shift - dvs_q;
  assign div_ge    = (div_shift >= dvs_q);
  assign div_rem   = div_ge ? div_trial : div_shift;

  // sign correction of the magnitude results
  logic [W2-1:0] prod_fix;
  logic [W-1:0]  quo_fix, rem_fix;
  assign prod_fix = (sign_a ^ sign_b) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = sign_a ? -acc_q[W2-1:W] : acc_q[W2-1:W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // a start wins over coincident HI/LO writes
          state_d = S_PREP;
          op_d    = i_op;
          opa_d   = i_op_a;
          opb_d   = i_op_b;
        end else begin
          if (i_mthi) hi_d = i_wr_data;
          if (i_mtlo) lo_d = i_wr_data;
        end
      end
      S_PREP: begin
        if (is_div && opb_q == '0) begin
          state_d = S_DONE;
          hi_d    = opa_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
          dvs_d   = mag_b;
          if (is_div) begin
            acc_d = {{W{1'b0}}, mag_a[W-1:0]};
          end else begin
            acc_d = '0;
            mcd_d = {{(W-1){1'b0}}, mag_a};
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;   // wraps to 0 on the last step
        if (is_div) begin
          acc_d = {div_rem[W-1:0], acc_q[W-2:0], div_ge};
        end else begin
          if (dvs_q[0]) acc_d = acc_q + mcd_q;
          mcd_d = mcd_q << 1;
          dvs_d = dvs_q >> 1;
        end
        if (cnt_q == 5'(ITER_COUNT-1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[W2-1:W];
          lo_d = prod_fix[W-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort: back to IDLE with no completion and no result write
    if (i_flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      mcd_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_div_by_zero = dbz_q & o_done;
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0, i_start = 1'b0, i_flush = 1'b0;
  logic        i_mthi = 1'b0, i_mtlo = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_op_a = '0, i_op_b = '0, i_wr_data = '0;
  logic        o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.DATA_SIZE(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
    .i_mthi(i_mthi), .i_mtlo(i_mtlo), .i_wr_data(i_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_div_by_zero(o_div_by_zero),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an op, scramble the operand inputs after acceptance, and watch up
  // to 40 edges. de = edges after the accepting edge at which o_done was seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int de, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dbz, output logic bok);
    i_op = op; i_op_a = a; i_op_b = b; i_start = 1'b1;
    step();
    i_start = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0;
    i_op = ~op; i_op_a = ~a; i_op_b = b + 32'd1;
    de = -1; hi = '0; lo = '0; dbz = 1'b0; bok = o_busy;
    for (int k = 1; k <= 40 && de < 0; k++) begin
      step();
      bok = bok & o_busy;
      if (o_done) begin
        de = k; hi = o_hi; lo = o_lo; dbz = o_div_by_zero;
      end
    end
  endtask

  int          de;
  logic [31:0] rhi, rlo;
  logic        rdbz, bok;
  int          ndone;

  initial begin
    // reset
    i_reset = 1'b1; step(); step(); i_reset = 1'b0;
    chk("rst_hi", 64'(o_hi), 64'h0);
    chk("rst_lo", 64'(o_lo), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_done", 64'(o_done), 64'h0);
    chk("rst_dbz", 64'(o_div_by_zero), 64'h0);

    // MULTU max x max
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, de, rhi, rlo, rdbz, bok);
    chk("multu_edge", 64'(de), 64'd34);
    chk("multu_busy", 64'(bok), 64'h1);
    chk("multu_hi", 64'(rhi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(rlo), 64'h00000001);
    chk("multu_dbz", 64'(rdbz), 64'h0);
    step();
    chk("multu_idle", 64'({o_busy, o_done}), 64'h0);
    chk("multu_hold_hi", 64'(o_hi), 64'hFFFFFFFE);

    // MULT -3 x 5 = -15
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, de, rhi, rlo, rdbz, bok);
    chk("mult_edge", 64'(de), 64'd34);
    chk("mult_hi", 64'(rhi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(rlo), 64'hFFFFFFF1);
    step();

    // DIV -7 / 2 = -3 rem -1
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, de, rhi, rlo, rdbz, bok);
    chk("div_edge", 64'(de), 64'd34);
    chk("div_lo", 64'(rlo), 64'hFFFFFFFD);
    chk("div_hi", 64'(rhi), 64'hFFFFFFFF);
    chk("div_dbz", 64'(rdbz), 64'h0);
    step();

    // DIVU 0xFFFFFFF9 / 2
    run_op(2'b11, 32'hFFFFFFF9, 32'h2, de, rhi, rlo, rdbz, bok);
    chk("divu_lo", 64'(rlo), 64'h7FFFFFFC);
    chk("divu_hi", 64'(rhi), 64'h00000001);
    step();

    // most-negative / -1 wraps with no error flag
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, de, rhi, rlo, rdbz, bok);
    chk("ovf_lo", 64'(rlo), 64'h80000000);
    chk("ovf_hi", 64'(rhi), 64'h0);
    chk("ovf_dbz", 64'(rdbz), 64'h0);
    step();

    // divide by zero: PREP goes straight to DONE, i.e. the second edge
    // counting the accepting edge as the first
    run_op(2'b10, 32'h12345678, 32'h0, de, rhi, rlo, rdbz, bok);
    chk("dbz_edge", 64'(de), 64'd1);
    chk("dbz_hi", 64'(rhi), 64'h12345678);
    chk("dbz_lo", 64'(rlo), 64'hFFFFFFFF);
    chk("dbz_flag", 64'(rdbz), 64'h1);
    step();
    chk("dbz_flag_clr", 64'(o_div_by_zero), 64'h0);

    // mthi / mtlo
    i_wr_data = 32'hAAAA0000; i_mthi = 1'b1; step(); i_mthi = 1'b0;
    i_wr_data = 32'h00005555; i_mtlo = 1'b1; step(); i_mtlo = 1'b0;
    chk("mthi", 64'(o_hi), 64'hAAAA0000);
    chk("mtlo", 64'(o_lo), 64'h00005555);

    // start, ignored second start + mthi at +5, start+flush at +10
    i_op = 2'b01; i_op_a = 32'h3; i_op_b = 32'h7; i_start = 1'b1;
    step();                                   // edge +0 accepts
    i_start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    i_start = 1'b1; i_op = 2'b10; i_op_b = 32'h0; i_mthi = 1'b1; i_wr_data = 32'h1234;
    step();                                   // edge +5
    i_start = 1'b0; i_mthi = 1'b0;
    chk("busy_mthi_ign", 64'(o_hi), 64'hAAAA0000);
    chk("busy_restart_ign", 64'(o_done), 64'h0);
    for (int k = 6; k <= 9; k++) step();
    i_start = 1'b1; i_flush = 1'b1;
    step();                                   // edge +10
    i_start = 1'b0; i_flush = 1'b0;
    chk("flush_idle", 64'(o_busy), 64'h0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin step(); if (o_done) ndone++; end
    chk("flush_no_done", 64'(ndone), 64'h0);
    chk("flush_hi", 64'(o_hi), 64'hAAAA0000);
    chk("flush_lo", 64'(o_lo), 64'h00005555);

    // start coinciding with mtlo: start wins, LO not written
    i_mtlo = 1'b1; i_wr_data = 32'hDEADBEEF;
    run_op(2'b11, 32'd100, 32'd7, de, rhi, rlo, rdbz, bok);
    chk("start_mtlo_q", 64'(rlo), 64'd14);
    chk("start_mtlo_r", 64'(rhi), 64'd2);
    step();

    // flush ignored in IDLE; both strobes together
    i_flush = 1'b1; i_mthi = 1'b1; i_mtlo = 1'b1; i_wr_data = 32'hCAFEF00D;
    step();
    i_flush = 1'b0; i_mthi = 1'b0; i_mtlo = 1'b0;
    chk("both_wr", 64'({o_hi, o_lo}), 64'hCAFEF00D_CAFEF00D);
    chk("idle_flush_busy", 64'(o_busy), 64'h0);

    // reset mid-MULTU at edge +20
    i_op = 2'b01; i_op_a = 32'hFFFFFFFF; i_op_b = 32'hFFFFFFFF; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 19; k++) step();
    i_reset = 1'b1; i_flush = 1'b1; i_mthi = 1'b1;
    step();                                   // edge +20
    i_reset = 1'b0; i_flush = 1'b0; i_mthi = 1'b0;
    chk("mid_rst_out", 64'({o_hi, o_lo}), 64'h0);
    chk("mid_rst_flags", 64'({o_busy, o_done, o_div_by_zero}), 64'h0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin step(); if (o_done) ndone++; end
    chk("mid_rst_no_done", 64'(ndone), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
